// File: rtl/updown_load_counter.sv
// Up/down counter with parallel load: count updates one clk after inputs, registered output.
// No backpressure: load > count-enable > hold each edge; rst_n (active-high) clears asynchronously.
module updown_load_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             VPWR,
    input  logic             VGND,
    input  logic             en,
    input  logic             dn,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    // Supply pins are physical pass-throughs and must never reach the counter logic.
    logic             w_unused_supply;

    assign w_unused_supply = VPWR ^ VGND;

    always_comb begin
        w_count_nxt = r_count;
        if (load) begin
            w_count_nxt = data;
        end else if (en) begin
            w_count_nxt = dn ? (r_count - STEP) : (r_count + STEP);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_updown_load_counter.sv
module tb_updown_load_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         VPWR;
    logic         VGND;
    logic         en;
    logic         dn;
    logic         load;
    logic [W-1:0] data;
    logic [W-1:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    updown_load_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .VPWR  (VPWR),
        .VGND  (VGND),
        .en    (en),
        .dn    (dn),
        .load  (load),
        .data  (data),
        .count (count)
    );

    // First rising edge at t=25 so the reset pulse at t=3..8 sees no clock edge.
    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         en;
        logic         dn;
        logic         load;
        logic [W-1:0] data;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic d, input logic l,
                                input int dat, input int ex, input string nm);
        vec_t v;
        v.en   = e;
        v.dn   = d;
        v.load = l;
        v.data = W'(dat);
        v.exp  = W'(ex);
        v.name = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: count=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int model;
    int r_rst;

    initial begin
        VPWR  = 1'b1;
        VGND  = 1'b0;
        rst_n = 1'b0;
        en    = 1'b0;
        dn    = 1'b0;
        load  = 1'b0;
        data  = '0;

        // Asynchronous reset pulse with no clock edge inside it.
        #3 rst_n = 1'b1;
        #1 check("reset_async", count, 4'd0);
        #4 rst_n = 1'b0;
        #1 check("reset_release", count, 4'd0);
        step();
        check("reset_hold_en0_a", count, 4'd0);
        step();
        check("reset_hold_en0_b", count, 4'd0);

        // Vector table: each row is applied for one edge, then count is checked.
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(1, 0, 0, 0, i, "count_up"));
        vecs.push_back(mk(1, 0, 1, 7, 7,  "load_with_en"));
        vecs.push_back(mk(1, 0, 0, 0, 8,  "after_load_up1"));
        vecs.push_back(mk(1, 0, 0, 0, 9,  "after_load_up2"));
        vecs.push_back(mk(1, 1, 0, 0, 8,  "count_down1"));
        vecs.push_back(mk(1, 1, 0, 0, 7,  "count_down2"));
        vecs.push_back(mk(0, 0, 1, 0, 0,  "load_zero"));
        vecs.push_back(mk(1, 1, 0, 0, 15, "wrap_down"));
        vecs.push_back(mk(1, 1, 1, 3, 3,  "load_beats_down"));
        vecs.push_back(mk(0, 0, 1, 15, 15, "load_max"));
        vecs.push_back(mk(1, 0, 0, 0, 0,  "wrap_up"));
        vecs.push_back(mk(0, 1, 0, 9, 0,  "hold_dn1"));
        vecs.push_back(mk(0, 0, 0, 9, 0,  "hold_dn0"));
        vecs.push_back(mk(0, 1, 0, 9, 0,  "hold_dn1b"));
        vecs.push_back(mk(0, 1, 1, 7, 7,  "load_disabled"));
        vecs.push_back(mk(0, 0, 0, 2, 7,  "hold_after_load_dn0"));
        vecs.push_back(mk(0, 1, 0, 2, 7,  "hold_after_load_dn1"));

        foreach (vecs[i]) begin
            en   = vecs[i].en;
            dn   = vecs[i].dn;
            load = vecs[i].load;
            data = vecs[i].data;
            step();
            check(vecs[i].name, count, vecs[i].exp);
        end

        // Reset asserted between edges while load and en are active.
        en   = 1'b1;
        dn   = 1'b0;
        load = 1'b1;
        data = 4'd5;
        step();
        check("pre_reset_load", count, 4'd5);
        #2 rst_n = 1'b1;
        #1 check("reset_mid_load_async", count, 4'd0);
        step();
        check("reset_priority_edge1", count, 4'd0);
        step();
        check("reset_priority_edge2", count, 4'd0);
        #2 rst_n = 1'b0;
        step();
        check("reset_release_load", count, 4'd5);
        load = 1'b0;
        step();
        check("reset_release_count", count, 4'd6);

        // Randomized phase against an arithmetic model; supply pins wiggle freely.
        model = 6;
        for (int n = 0; n < 400; n++) begin
            en    = 1'($urandom);
            dn    = 1'($urandom);
            load  = ($urandom_range(0, 5) == 0);
            data  = W'($urandom);
            VPWR  = 1'($urandom);
            VGND  = 1'($urandom);
            r_rst = ($urandom_range(0, 24) == 0) ? 1 : 0;
            rst_n = r_rst[0];
            if (r_rst != 0) begin
                #1 check("rand_reset_async", count, 4'd0);
            end
            step();
            if (r_rst != 0)   model = 0;
            else if (load)    model = int'(data);
            else if (en && dn) model = (model + MOD - 1) % MOD;
            else if (en)      model = (model + 1) % MOD;
            check("rand", count, W'(model));
            rst_n = 1'b0;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
